// File: rtl/pixel_pkg.sv
// Shared screen geometry, the queued pixel record and the writer state encoding.
package pixel_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOR_W  = 3;
    localparam int COORD_W  = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWEEP
    } state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO of pixel_t; full is registered from the post-edge occupancy.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  pixel_t din,
    output pixel_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    pixel_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_next = count - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_writer.sv
// Clips and queues plot requests, feeds the VGA write port, and runs a full-screen clear sweep.
// Optional drop counter enabled by defining PIXEL_WRITER_DROP_COUNT_EN.
module pixel_writer
    import pixel_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int DEPTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COLOR_W-1:0] color,
    input  logic               plot,
    input  logic               clear,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic               vga_ready,
    output logic [COORD_W-1:0] vga_x,
    output logic [COORD_W-1:0] vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_plot,
    output logic               full,
`ifdef PIXEL_WRITER_DROP_COUNT_EN
    output logic [15:0]        drop_count,
`endif
    output logic               busy
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

    state_t             state;
    state_t             state_next;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic [COLOR_W-1:0] bg;
    pixel_t             fifo_din;
    pixel_t             fifo_dout;
    logic               fifo_empty;
    logic               on_screen;
    logic               push;
    logic               pop;
    logic               sweep_emit;
    logic               sweep_last;
    logic               clear_go;

    assign on_screen  = (x <= X_LAST) && (y <= Y_LAST);
    assign push       = plot && on_screen && !full;
    // FIFO is served in IDLE and DRAIN so queued pixels land before the clear.
    assign pop        = !fifo_empty && vga_ready && (state != SWEEP);
    assign sweep_emit = (state == SWEEP) && vga_ready;
    assign sweep_last = (cx == X_LAST) && (cy == Y_LAST);
    assign clear_go   = clear && (state == IDLE);
    assign busy       = (state != IDLE);
    assign fifo_din   = '{x, y, color};

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear) state_next = DRAIN;
            DRAIN:   if (fifo_empty) state_next = SWEEP;
            SWEEP:   if (sweep_emit && sweep_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx        <= '0;
            cy        <= '0;
            bg        <= '0;
            vga_plot  <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
        end else begin
            vga_plot <= pop || sweep_emit;
            if (clear_go) begin
                cx <= '0;
                cy <= '0;
                bg <= bg_color;
            end else if (sweep_emit) begin
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= cy + COORD_W'(1);
                end else begin
                    cx <= cx + COORD_W'(1);
                end
            end
            if (pop) begin
                vga_x     <= fifo_dout.x;
                vga_y     <= fifo_dout.y;
                vga_color <= fifo_dout.color;
            end else if (sweep_emit) begin
                vga_x     <= cx;
                vga_y     <= cy;
                vga_color <= bg;
            end
        end
    end

`ifdef PIXEL_WRITER_DROP_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_count <= '0;
        else if (clear_go)
            drop_count <= '0;
        else if (plot && !push && (drop_count != '1))
            drop_count <= drop_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: directed steps with random sweep/plot traffic, checked against a queue model.
module tb_pixel_writer;
    import pixel_pkg::*;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int D     = 8;
    localparam int TOTAL = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] x, y;
    logic [2:0] color, bg_color;
    logic       plot, clear, vga_ready;
    logic [7:0] vga_x, vga_y;
    logic [2:0] vga_color;
    logic       vga_plot, full, busy;
`ifdef PIXEL_WRITER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    pixel_writer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .color     (color),
        .plot      (plot),
        .clear     (clear),
        .bg_color  (bg_color),
        .vga_ready (vga_ready),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_plot  (vga_plot),
        .full      (full),
`ifdef PIXEL_WRITER_DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .busy      (busy)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    // Reference model: accepted pixels in arrival order, plus a pending sweep of TOTAL writes.
    px_t mq[$];
    int  pre_clear, sweep_left, bgm, occ, drops;
    int  last_x, last_y, last_c, pulses;
    int  vectors, miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pre_clear  = 0;
        sweep_left = 0;
        bgm        = 0;
        occ        = 0;
        drops      = 0;
        last_x     = 0;
        last_y     = 0;
        last_c     = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_plot(input int px, input int py, input int pc);
        x     = 8'(px);
        y     = 8'(py);
        color = 3'(pc);
        plot  = 1'b1;
        if (px < W && py < H && occ < D) begin
            mq.push_back('{px, py, pc});
            occ++;
        end else begin
            drops++;
        end
    endtask

    task automatic start_clear(input int c);
        bg_color   = 3'(c);
        clear      = 1'b1;
        bgm        = c;
        pre_clear  = mq.size();
        sweep_left = TOTAL;
        drops      = 0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        for (int n = 0; n < limit && (mq.size() > 0 || sweep_left > 0); n++)
            step();
        chk(tag, mq.size() + sweep_left, 0);
    endtask

    task automatic chk_drops();
`ifdef PIXEL_WRITER_DROP_COUNT_EN
        chk("drop_count", drop_count, drops);
`endif
    endtask

    // Every adapter write is matched against the model; idle cycles must hold the last pixel.
    always @(negedge clk) begin : monitor
        px_t e;
        int  k;
        bit  have;
        if (reset === 1'b1) begin
            if (vga_plot === 1'b1) begin
                have = 1'b1;
                pulses++;
                if (pre_clear > 0) begin
                    e = mq.pop_front();
                    pre_clear--;
                end else if (sweep_left > 0) begin
                    k   = TOTAL - sweep_left;
                    e.x = k % W;
                    e.y = k / W;
                    e.c = bgm;
                    sweep_left--;
                end else if (mq.size() > 0) begin
                    e = mq.pop_front();
                end else begin
                    have = 1'b0;
                    chk("spurious_plot", 1, 0);
                end
                if (have) begin
                    chk("vga_x", vga_x, e.x);
                    chk("vga_y", vga_y, e.y);
                    chk("vga_color", vga_color, e.c);
                    last_x = e.x;
                    last_y = e.y;
                    last_c = e.c;
                end
            end else begin
                chk("vga_plot_low", vga_plot, 0);
                chk("hold_x", vga_x, last_x);
                chk("hold_y", vga_y, last_y);
                chk("hold_color", vga_color, last_c);
            end
        end
    end

    initial begin
        int p0;
        vectors = 0; miscompares = 0; pulses = 0;
        reset = 1'b0; plot = 1'b0; clear = 1'b0; vga_ready = 1'b0;
        x = '0; y = '0; color = '0; bg_color = '0;
        model_reset();

        // Reset state
        #12;
        chk("rst_vga_plot", vga_plot, 0);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_vga_color", vga_color, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk_drops();
        reset = 1'b1;
        step();

        // Single pixel, minimum latency
        vga_ready = 1'b1;
        do_plot(10, 20, 5);
        step();
        plot = 1'b0;
        chk("lat_edge1_plot", vga_plot, 0);
        step();
        chk("lat_edge2_plot", vga_plot, 1);
        chk("lat_x", vga_x, 10);
        chk("lat_y", vga_y, 20);
        chk("lat_color", vga_color, 5);
        step();
        chk("lat_one_cycle", vga_plot, 0);
        occ = 0;

        // Fill while stalled: 8 queued, 9th dropped, then drained in order
        vga_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_plot(i * 7 + 3, i * 5 + 1, i % 8);
            step();
        end
        plot = 1'b0;
        chk("fill_full", full, 1);
        chk_drops();
        repeat (3) step();
        p0 = pulses;
        vga_ready = 1'b1;
        wait_drain("fill_drain_timeout", 40);
        repeat (2) step();
        chk("fill_pulses", pulses - p0, 8);
        chk("fill_not_full", full, 0);
        occ = 0;

        // Off-screen clipping
        do_plot(160, 5, 2);
        step();
        do_plot(5, 120, 4);
        step();
        plot = 1'b0;
        p0 = pulses;
        repeat (4) step();
        chk("clip_no_plot", pulses - p0, 0);
        chk("clip_not_full", full, 0);
        chk_drops();

        // Queued pixels land before a full clear sweep
        vga_ready = 1'b0;
        do_plot(1, 2, 3);
        step();
        do_plot(100, 50, 6);
        step();
        do_plot(159, 119, 7);
        step();
        plot = 1'b0;
        vga_ready = 1'b1;
        start_clear(1);
        step();
        clear = 1'b0;
        chk("clear_busy", busy, 1);
        chk_drops();
        wait_drain("sweep1_timeout", 20000);
        chk("sweep1_busy_low", busy, 0);
        occ = 0;

        // Randomised ready during a sweep, plots queued behind it, clears ignored
        start_clear(int'($urandom_range(0, 7)));
        step();
        clear = 1'b0;
        for (int n = 0; n < 100 && sweep_left == TOTAL; n++)
            step();
        chk("sweep2_started", (sweep_left < TOTAL) ? 1 : 0, 1);
        for (int i = 0; i < 14; i++) begin
            vga_ready = ($urandom_range(0, 3) != 0);
            do_plot(int'($urandom_range(0, 170)), int'($urandom_range(0, 125)),
                    int'($urandom_range(0, 7)));
            clear    = (i % 4 == 1);
            bg_color = 3'($urandom_range(0, 7));
            step();
        end
        plot  = 1'b0;
        clear = 1'b0;
        chk("sweep2_busy", busy, 1);
        chk_drops();
        for (int n = 0; n < 60000 && (sweep_left > 0 || mq.size() > 0); n++) begin
            vga_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("sweep2_timeout", mq.size() + sweep_left, 0);
        chk("sweep2_busy_low", busy, 0);
        occ = 0;

        // Reset in the middle of a sweep with a full FIFO
        vga_ready = 1'b1;
        start_clear(2);
        step();
        clear = 1'b0;
        for (int n = 0; n < 300 && sweep_left > TOTAL - 20; n++)
            step();
        for (int i = 0; i < 8; i++) begin
            do_plot(i + 30, i + 40, i);
            step();
        end
        plot = 1'b0;
        chk("midrst_pre_full", full, 1);
        chk("midrst_pre_busy", busy, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_vga_plot", vga_plot, 0);
        chk("midrst_full", full, 0);
        chk("midrst_vga_x", vga_x, 0);
        chk_drops();
        step();
        #2;
        reset = 1'b1;
        step();
        do_plot(1, 1, 7);
        step();
        plot = 1'b0;
        chk("post_rst_edge1", vga_plot, 0);
        step();
        chk("post_rst_plot", vga_plot, 1);
        chk("post_rst_x", vga_x, 1);
        chk("post_rst_y", vga_y, 1);
        chk("post_rst_color", vga_color, 7);
        step();
        chk("post_rst_one_cycle", vga_plot, 0);
        wait_drain("final_timeout", 20);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
